// File: rtl/sum_sched_pkg.sv
// Shared types and constants for the operand-queue adder scheduler.
package sum_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int DEF_DEPTH = 4;
   localparam int DEF_W     = 4;

   // uio_in control bits
   localparam int PUSH  = 0;
   localparam int ACK   = 1;
   localparam int CLR   = 2;
   // uio_out status bits
   localparam int VALID = 4;
   localparam int EMPTY = 5;
   localparam int FULL  = 6;
   localparam int OVF   = 7;

endpackage

// File: rtl/sum_sched_opq.sv
// Synchronous operand FIFO; a push is still taken when full if a pop frees the slot.
module sum_opq #(
   parameter int DEPTH = 4,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [DW-1:0] data,
   output logic [DW-1:0] head,
   output logic          empty,
   output logic          full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty & ~flush;
   assign do_push = push & (~full | do_pop) & ~flush;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= data;
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tt_um_sum_sched.sv
// Buffers operand pairs and feeds them one at a time through a shared adder;
// each result is held on uo_out until acknowledged.
module tt_um_sum_sched
   import sum_sched_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int W     = DEF_W
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   state_t         state;
   logic [2:0]     prev;
   logic [W-1:0]   opa;
   logic [W-1:0]   opb;
   logic [W:0]     result;
   logic           overflow;
   logic           push_rise;
   logic           ack_rise;
   logic           clr_rise;
   logic           pop;
   logic           q_empty;
   logic           q_full;
   logic [2*W-1:0] q_head;
   logic [2*W-1:0] q_data;
   logic           unused;

   assign push_rise = uio_in[PUSH] & ~prev[PUSH];
   assign ack_rise  = uio_in[ACK]  & ~prev[ACK];
   assign clr_rise  = uio_in[CLR]  & ~prev[CLR];
   assign pop       = (state == IDLE) & ~q_empty;
   assign q_data    = {ui_in[4+W-1:4], ui_in[W-1:0]};
   assign unused    = &{1'b0, ena, uio_in[7:3]};

   sum_opq #(
      .DEPTH (DEPTH),
      .DW    (2 * W)
   ) u_opq (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_rise),
      .pop   (pop),
      .flush (clr_rise),
      .data  (q_data),
      .head  (q_head),
      .empty (q_empty),
      .full  (q_full)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev     <= 3'b111;
         state    <= IDLE;
         opa      <= '0;
         opb      <= '0;
         result   <= '0;
         overflow <= 1'b0;
      end else begin
         prev <= uio_in[2:0];
         if (clr_rise) begin
            state    <= IDLE;
            opa      <= '0;
            opb      <= '0;
            result   <= '0;
            overflow <= 1'b0;
         end else begin
            // A same-cycle pop frees a slot, so only a push with no pop is dropped.
            if (push_rise && q_full && !pop) overflow <= 1'b1;
            case (state)
               IDLE: begin
                  if (!q_empty) begin
                     opa   <= q_head[W-1:0];
                     opb   <= q_head[2*W-1:W];
                     state <= ADD;
                  end
               end
               ADD: begin
                  result <= {1'b0, opa} + {1'b0, opb};
                  state  <= HOLD;
               end
               HOLD: begin
                  if (ack_rise) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   always_comb begin
      uio_out        = 8'h00;
      uio_out[VALID] = (state == HOLD);
      uio_out[EMPTY] = q_empty;
      uio_out[FULL]  = q_full;
      uio_out[OVF]   = overflow;
   end

   assign uo_out = {{(7 - W){1'b0}}, result};
   assign uio_oe = 8'hF0;

endmodule

// File: tb/tb_tt_um_sum_sched.sv
// Bench for tt_um_sum_sched: directed scenarios plus random control traffic
// checked cycle by cycle against a transaction-level queue model.
module tb_tt_um_sum_sched;

   localparam int DEPTH = 4;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [7:0] mq[$];
   logic [7:0] cur;
   int         mode;   // 0 waiting for work, 1 adding, 2 showing result
   logic [4:0] mres;
   logic       movf;
   logic [2:0] mprev;
   logic [7:0] exp_q[$];
   logic       dut_valid_d;

   tt_um_sum_sched dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      mq.delete();
      cur   = '0;
      mode  = 0;
      mres  = '0;
      movf  = 1'b0;
      mprev = 3'b111;
   endfunction

   function automatic void model_edge(input logic p, input logic k, input logic c,
                                      input logic [7:0] data);
      logic pr, kr, cr;
      pr    = p & ~mprev[0];
      kr    = k & ~mprev[1];
      cr    = c & ~mprev[2];
      mprev = {c, k, p};
      if (cr) begin
         mq.delete();
         cur  = '0;
         mode = 0;
         mres = '0;
         movf = 1'b0;
      end else begin
         case (mode)
            0: if (mq.size() != 0) begin
                  cur  = mq.pop_front();
                  mode = 1;
               end
            1: begin
                  mres = 5'(cur[3:0]) + 5'(cur[7:4]);
                  exp_q.push_back({3'b000, mres});
                  mode = 2;
               end
            default: if (kr) mode = 0;
         endcase
         if (pr) begin
            if (mq.size() < DEPTH) mq.push_back(data);
            else movf = 1'b1;
         end
      end
   endfunction

   task automatic compare_all();
      logic [7:0] exp_uio;
      exp_uio = {movf, (mq.size() == DEPTH), (mq.size() == 0), (mode == 2), 4'b0000};
      check("uo_out", uo_out, {3'b000, mres});
      check("uio_out", uio_out, exp_uio);
      if (uio_out[4] && !dut_valid_d) begin
         if (exp_q.size() == 0) check("sb_unexpected", uo_out, 8'hxx);
         else check("sb_result", uo_out, exp_q.pop_front());
      end
      dut_valid_d = uio_out[4];
   endtask

   // drivers
   task automatic step(input logic p, input logic k, input logic c,
                       input logic [3:0] a, input logic [3:0] b);
      @(negedge clk);
      uio_in = {5'b00000, c, k, p};
      ui_in  = {b, a};
      @(posedge clk);
      model_edge(p, k, c, {b, a});
      #1;
      compare_all();
   endtask

   task automatic push_pair(input logic [3:0] a, input logic [3:0] b);
      step(1'b1, 1'b0, 1'b0, a, b);
      step(1'b0, 1'b0, 1'b0, a, b);
   endtask

   task automatic ack_pulse();
      step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
      step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
   endtask

   task automatic clr_pulse();
      step(1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
      step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
   endtask

   initial begin
      ena    = 1'b1;
      rst_n  = 1'b0;
      ui_in  = 8'h53;
      uio_in = 8'h01;
      dut_valid_d = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // push held high through reset release: no event
      step(1'b1, 1'b0, 1'b0, 4'h3, 4'h5);
      check("rst_uo", uo_out, 8'h00);
      check("rst_flags", {4'h0, uio_out[7:4]}, 8'h02);
      check("uio_oe", uio_oe, 8'hF0);
      idle(3);
      check("rst_no_entry", {7'b0, uio_out[5]}, 8'h01);

      // 3 + 5 with 2-cycle latency, result stays after ack
      step(1'b1, 1'b0, 1'b0, 4'h3, 4'h5);
      check("lat_e0_valid", {7'b0, uio_out[4]}, 8'h00);
      step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
      check("lat_e1_valid", {7'b0, uio_out[4]}, 8'h00);
      step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
      check("sum35_valid", {7'b0, uio_out[4]}, 8'h01);
      check("sum35", uo_out, 8'h08);
      ack_pulse();
      check("ack_valid", {7'b0, uio_out[4]}, 8'h00);
      check("ack_keep", uo_out, 8'h08);

      // no wrap
      push_pair(4'hF, 4'hF);
      idle(1);
      check("sum_ff", uo_out, 8'h1E);
      ack_pulse();

      // fill, overflow, drain in order
      push_pair(4'h1, 4'h1);
      push_pair(4'h2, 4'h3);
      push_pair(4'h4, 4'h4);
      push_pair(4'h6, 4'h1);
      push_pair(4'h7, 4'h7);
      check("fill_full", {7'b0, uio_out[6]}, 8'h01);
      check("fill_ovf0", {7'b0, uio_out[7]}, 8'h00);
      push_pair(4'h9, 4'h9);
      check("ovf_set", {7'b0, uio_out[7]}, 8'h01);
      for (int i = 0; i < 5; i++) begin
         ack_pulse();
         idle(2);
      end
      check("drain_empty", {7'b0, uio_out[5]}, 8'h01);
      check("drain_last", uo_out, 8'h0E);
      check("ovf_sticky", {7'b0, uio_out[7]}, 8'h01);
      clr_pulse();

      // full queue, pop and push in the same cycle
      for (int i = 0; i < 5; i++) push_pair(4'(i + 1), 4'h2);
      step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
      step(1'b1, 1'b0, 1'b0, 4'hA, 4'h5);
      check("pp_full", {7'b0, uio_out[6]}, 8'h01);
      check("pp_ovf", {7'b0, uio_out[7]}, 8'h00);
      idle(2);

      // clear while holding with entries queued
      clr_pulse();
      push_pair(4'h2, 4'h2);
      push_pair(4'h3, 4'h3);
      push_pair(4'h4, 4'h4);
      clr_pulse();
      check("clr_uo", uo_out, 8'h00);
      check("clr_uio", uio_out, 8'h20);
      idle(6);
      check("clr_quiet", uio_out, 8'h20);

      // random control traffic
      for (int i = 0; i < 1500; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 63) == 0),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end

      // let any in-flight result appear, then the scoreboard must be drained
      idle(3);
      check("sb_drain", 8'(exp_q.size()), 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tt_um_sum_sched.md
# tt_um_sum_sched

Operand-queue scheduler for the project's 4-bit adder: it buffers up to DEPTH operand pairs pushed from the input switches and feeds them one at a time through a single shared adder. Each result is held on the 7-segment outputs until the user acknowledges it. It is a standalone Tiny Tapeout user module using the standard `tt_um_*` pin set, with the bidirectional pins split into control inputs and status outputs.

## Interface
- DEPTH, 4: operand-queue depth; power of two, 2..8.
- W, 4: operand width; the result is W+1 bits.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- ena  in  1  design enable; ignored, the block is always active.
- ui_in  in  8  [3:0] operand A, [7:4] operand B; sampled on an accepted push.
- uio_in  in  8  [0] push, [1] ack, [2] clear; [7:3] unused.
- uo_out  out  8  result as {3'b0, sum[4:0]}.
- uio_out  out  8  [3:0] = 0; [4] valid; [5] empty; [6] full; [7] overflow (sticky).
- uio_oe  out  8  constant 8'hF0.

## Operation
- Edge detect on push, ack and clear:
  - Each line has a previous-value register; prev_* reset to 1.
  - `x_rise = uio_in[i] & ~prev_i`, evaluated combinationally each cycle.
  - A line held high through reset release produces no event.
- Queue: FIFO of {A, B} pairs, DEPTH entries, with wrap-around read/write pointers and a count from 0 to DEPTH.
  - empty = (count == 0); full = (count == DEPTH).
- push_rise while not full: the pair from ui_in is written at the tail.
- push_rise while full: the pair is dropped and overflow is set to 1. Overflow stays set until reset or clear.
- FSM states are IDLE, ADD and HOLD.
  - IDLE → ADD when not empty. The head entry is popped into the operand registers opA/opB.
  - ADD → HOLD unconditionally. The result register is loaded with `opA + opB`, zero-extended to W+1 bits; there is no wrap (15+15 = 30).
  - HOLD → IDLE on ack_rise. The result register keeps its last value; valid drops.
- valid = 1 exactly while in HOLD.
- uo_out shows the result register at all times, so the last result stays visible after ack.
- Push and pop in the same cycle (IDLE pop, push_rise):
  - Both occur and count is unchanged.
  - If the queue was full, the push is accepted because the pop frees a slot, and overflow is not set.
- ack_rise outside HOLD is ignored.
- clear_rise, in any state, has the same effect as reset on everything except the prev_* registers:
  - queue flushed and pointers/count set to 0;
  - FSM returns to IDLE;
  - result, operand registers and overflow set to 0.
  - clear takes priority over push, ack and pop in the same cycle.
- Reset values:
  - uo_out = 8'h00;
  - uio_out = 8'b0010_0000 (empty = 1, all other flags 0);
  - FSM = IDLE; pointers and count = 0.

## Timing
- The push pair is written at the edge where push_rise is true (edge E0).
- The pair is popped at E1 and the result is loaded at E2. valid = 1 and uo_out is updated from E2 onward.
- Push-to-valid latency is 2 cycles when the queue was empty and the FSM was idle.
- ack_rise at edge Ek drops valid after Ek. The next queued pair is popped at Ek+1 and its result is valid after Ek+2.
- Steady-state spacing between results is 3 cycles plus the ack wait.
- Status flags (empty, full, overflow) are registered or derived from registered count. They reflect the edge at which the update occurred; there is no lookahead.

## Structure
- Package `sum_sched_pkg` holds:
  - the state enum (IDLE, ADD, HOLD);
  - default DEPTH and W;
  - the uio bit-index constants (PUSH, ACK, CLR, VALID, EMPTY, FULL, OVF).
- Sub-module `sum_opq`: a parameterised synchronous FIFO.
  - Inputs: push, pop, flush, data.
  - Outputs: head data, empty, full.
  - Behaviour: simultaneous push and pop is allowed when full.
- The top module holds the edge detectors, FSM, adder, result register and overflow flag.

## Test plan
- Reset with push held high, then release rst_n: no entry is written. uo_out = 0x00 and uio_out[7:4] = 4'b0010.
- Push A=3, B=5 with the queue empty: after 2 edges valid = 1 and uo_out = 0x08. An ack edge drops valid; uo_out stays 0x08.
- Push A=15, B=15: uo_out = 0x1E (no wrap).
- Push 5 pairs while the result stays unacknowledged:
  - the first pair goes to HOLD; the next 4 fill the queue, so full = 1;
  - a 6th push sets overflow = 1 and the dropped pair never appears;
  - acks then return 4 results in FIFO order.
- Full queue with the FSM in IDLE popping the head while push_rise arrives in the same cycle: the push is accepted, count stays at DEPTH and overflow stays 0.
- clear edge in HOLD with 2 pairs queued: valid = 0, empty = 1, uo_out = 0x00, overflow = 0. No further results appear without new pushes.
